// File: rtl/as_pack.sv
// Shared constants and register-map types for the as_* peripherals.
package as_pack;

  localparam int unsigned nr_gpios        = 8;
  localparam int unsigned gpio_addr_width = 8;
  localparam int unsigned GPIO_DATA_W     = 64;

  // Word index of each GPIO register (byte offset >> 3).
  typedef enum logic [2:0] {
    GPIO_DOUT = 3'd0,
    GPIO_DIR  = 3'd1,
    GPIO_DIN  = 3'd2,
    GPIO_SET  = 3'd3,
    GPIO_CLR  = 3'd4,
    GPIO_EDGE = 3'd5
  } gpio_reg_e;

  function automatic logic gpio_updates_dout(input gpio_reg_e r);
    return (r == GPIO_DOUT) || (r == GPIO_SET) || (r == GPIO_CLR);
  endfunction

endpackage

// File: rtl/as_sync2.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-high reset.
module as_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO: output/direction registers, synchronised inputs,
// rising-edge latch, and a cs_o strobe whenever the output value is rewritten.
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int unsigned          NR_GPIOS  = nr_gpios,
  parameter int unsigned          ADDR_W    = gpio_addr_width,
  parameter logic [NR_GPIOS-1:0]  DIR_RESET = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sel_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [GPIO_DATA_W-1:0] wdata_i,
  output logic [GPIO_DATA_W-1:0] rdata_o,
  output logic                   ack_o,
  inout  wire  [NR_GPIOS-1:0]    gpio_io,
  output logic                   cs_o
);

  localparam logic [ADDR_W-4:0] LAST_IDX = (ADDR_W-3)'(GPIO_EDGE);

  logic [NR_GPIOS-1:0] dout, dir, edge_lat, din, din_d, rise, edge_clr, wd, rd_val;
  logic [ADDR_W-4:0]   word;
  gpio_reg_e           reg_sel;
  logic                hit, wr;
  logic                unused_bits;

  assign unused_bits = ^{addr_i[2:0], wdata_i};

  assign word    = addr_i[ADDR_W-1:3];
  assign hit     = (word <= LAST_IDX);
  assign reg_sel = gpio_reg_e'(word[2:0]);
  assign wd      = wdata_i[NR_GPIOS-1:0];
  assign wr      = sel_i && we_i && hit;

  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
    assign gpio_io[i] = dir[i] ? dout[i] : 1'bz;
  end

  // Output pins loop back through the same path, so DIN shows the driven value.
  as_sync2 #(.W(NR_GPIOS)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (gpio_io),
    .q   (din)
  );

  assign rise = din & ~din_d;

  always_comb begin
    rd_val   = '0;
    edge_clr = '0;
    if (hit) begin
      case (reg_sel)
        GPIO_DOUT: rd_val = dout;
        GPIO_DIR:  rd_val = dir;
        GPIO_DIN:  rd_val = din;
        GPIO_EDGE: rd_val = edge_lat;
        default:   rd_val = '0;
      endcase
    end
    if (wr && reg_sel == GPIO_EDGE) edge_clr = wd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout     <= '0;
      dir      <= DIR_RESET;
      edge_lat <= '0;
      din_d    <= '0;
      rdata_o  <= '0;
      ack_o    <= 1'b0;
      cs_o     <= 1'b0;
    end else begin
      ack_o   <= sel_i;
      cs_o    <= wr && gpio_updates_dout(reg_sel);
      rdata_o <= (sel_i && !we_i) ? GPIO_DATA_W'(rd_val) : '0;
      din_d   <= din;
      // A fresh edge outranks a simultaneous write-one-to-clear.
      edge_lat <= (edge_lat & ~edge_clr) | rise;
      if (wr) begin
        case (reg_sel)
          GPIO_DOUT: dout <= wd;
          GPIO_DIR:  dir  <= wd;
          GPIO_SET:  dout <= dout | wd;
          GPIO_CLR:  dout <= dout & ~wd;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Directed bench for as_gpio_ctrl with a cycle model of the register map.
module tb_as_gpio_ctrl;
  import as_pack::*;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst, sel, we;
  logic [AW-1:0] addr;
  logic [63:0]   wdata, rdata;
  logic          ack, cs;
  wire  [N-1:0]  pins;
  logic [N-1:0]  ext_oe, ext_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign pins[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end

  as_gpio_ctrl #(
    .NR_GPIOS  (N),
    .ADDR_W    (AW),
    .DIR_RESET (8'hFF)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sel_i   (sel),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .gpio_io (pins),
    .cs_o    (cs)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: register values plus a history of sampled pin values (h[1] = DIN).
  logic [N-1:0] m_dout, m_dir, m_edge;
  logic [N-1:0] h [3];
  logic         e_ack, e_cs, e_rd;
  logic [63:0]  e_rdata;

  always @(posedge clk) begin : model
    logic [N-1:0] pin_now, rise, rv, wd, nedge;
    logic [7:0]   off;
    pin_now = (m_dir & m_dout) | (~m_dir & ext_oe & ext_val);
    if (rst) begin
      m_dout = '0; m_dir = '1; m_edge = '0;
      h[0] = '0; h[1] = '0; h[2] = '0;
      e_ack = 0; e_cs = 0; e_rd = 0; e_rdata = '0;
    end else begin
      off  = {addr[AW-1:3], 3'b000};
      wd   = wdata[N-1:0];
      rise = h[1] & ~h[2];
      case (off)
        8'h00:   rv = m_dout;
        8'h08:   rv = m_dir;
        8'h10:   rv = h[1];
        8'h28:   rv = m_edge;
        default: rv = '0;
      endcase
      e_ack   = sel;
      e_rd    = sel && !we;
      e_cs    = sel && we && (off == 8'h00 || off == 8'h18 || off == 8'h20);
      e_rdata = e_rd ? 64'(rv) : '0;
      nedge = m_edge;
      if (sel && we && off == 8'h28) nedge = nedge & ~wd;
      nedge = nedge | rise;
      if (sel && we) begin
        case (off)
          8'h00: m_dout = wd;
          8'h08: m_dir  = wd;
          8'h18: m_dout = m_dout | wd;
          8'h20: m_dout = m_dout & ~wd;
          default: ;
        endcase
      end
      m_edge = nedge;
      h[2] = h[1]; h[1] = h[0]; h[0] = pin_now;
    end
  end

  always @(posedge clk) begin : compare
    logic [N-1:0] mask, exp_pins;
    #2;
    mask     = m_dir | ext_oe;
    exp_pins = (m_dir & m_dout) | (~m_dir & ext_oe & ext_val);
    chk("m_ack", 64'(ack), 64'(e_ack));
    chk("m_cs", 64'(cs), 64'(e_cs));
    if (e_rd) chk("m_rdata", rdata, e_rdata);
    chk("m_pins", 64'(pins & mask), 64'(exp_pins & mask));
  end

  task automatic bus(input logic w, input logic [7:0] a, input logic [63:0] d);
    sel = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] d);
    bus(1'b0, a, 64'd0);
    chk("rd_ack", 64'(ack), 64'd1);
    d = rdata;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  logic [63:0] r;

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ext_oe = '0; ext_val = '0;
    repeat (10) @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_cs", 64'(cs), 64'd0);
    chk("rst_pins", 64'(pins), 64'h00);
    rst = 1'b0;
    rd(8'h10, r);
    chk("rst_din", r, 64'd0);

    bus(1'b1, 8'h00, 64'h80);
    chk("dout_ack", 64'(ack), 64'd1);
    chk("dout_cs", 64'(cs), 64'd1);
    chk("dout_pins", 64'(pins), 64'h80);
    idle();
    chk("dout_cs_low", 64'(cs), 64'd0);

    bus(1'b1, 8'h18, 64'h05);
    chk("set_cs", 64'(cs), 64'd1);
    chk("set_pins", 64'(pins), 64'h85);
    bus(1'b1, 8'h20, 64'h04);
    chk("clr_cs", 64'(cs), 64'd1);
    chk("clr_pins", 64'(pins), 64'h81);
    idle();
    chk("clr_cs_low", 64'(cs), 64'd0);

    ext_val = 8'h80; ext_oe = 8'hF0;
    bus(1'b1, 8'h08, 64'hFFFF_FFFF_FFFF_FF0F);
    chk("dir_no_cs", 64'(cs), 64'd0);
    ext_val = 8'h00;
    repeat (4) idle();
    bus(1'b1, 8'h28, 64'hFF);
    repeat (2) idle();
    ext_val = 8'hA0;
    rd(8'h10, r);
    idle();
    rd(8'h10, r);
    chk("din_ext", r, 64'hA1);
    chk("ext_pins", 64'(pins), 64'hA1);
    rd(8'h28, r);
    chk("edge_75", r, 64'hA0);

    ext_val = 8'h20;
    repeat (4) idle();
    ext_val = 8'hA0;
    repeat (2) idle();
    bus(1'b1, 8'h28, 64'h80);
    rd(8'h28, r);
    chk("edge_set_wins", r, 64'hA0);
    bus(1'b1, 8'h28, 64'h80);
    rd(8'h28, r);
    chk("edge_w1c", r, 64'h20);

    ext_oe = 8'h00;
    bus(1'b1, 8'h30, 64'hFF);
    chk("unmap_ack", 64'(ack), 64'd1);
    chk("unmap_cs", 64'(cs), 64'd0);
    rd(8'h30, r);
    chk("unmap_rd", r, 64'd0);
    rd(8'h00, r);
    chk("dout_keep", r, 64'h81);

    bus(1'b1, 8'h00, 64'h3C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drop_ack", 64'(ack), 64'd0);
    chk("rst_drop_cs", 64'(cs), 64'd0);
    sel = 1'b1; we = 1'b1; addr = 8'h00; wdata = 64'hFF; rst = 1'b1;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; rst = 1'b0;
    chk("rst_wr_cs", 64'(cs), 64'd0);
    chk("rst_wr_ack", 64'(ack), 64'd0);
    rd(8'h00, r);
    chk("rst_dout", r, 64'd0);
    chk("rst_pins2", 64'(pins), 64'h00);
    repeat (3) idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
